// File: rtl/divisor_pkg.sv
// Shared definitions for the parametrised sequential divider.
//   state_t      : controller states (IDLE, CALC, FIX)
//   DEFAULT_SIZE : default operand/result width
//   cnt_width()  : width of an iteration counter able to hold 0..size
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_SIZE = 8;

    // Counter width large enough to hold the value size.
    function automatic int cnt_width(input int s);
        return $clog2(s + 1);
    endfunction

endpackage

// File: rtl/divisor_param_if.sv
// Request/result bundle of the divider.
//   master : requester (drives start/signo/operands, receives results)
//   slave  : divider   (receives request, drives cociente/resto/done/busy/div_cero)
interface divisor_param_if #(
    parameter int size = 8
);
    logic            start;
    logic            signo;
    logic [size-1:0] numerador;
    logic [size-1:0] denominador;
    logic [size-1:0] cociente;
    logic [size-1:0] resto;
    logic            done;
    logic            busy;
    logic            div_cero;

    modport master (
        output start, signo, numerador, denominador,
        input  cociente, resto, done, busy, div_cero
    );

    modport slave (
        input  start, signo, numerador, denominador,
        output cociente, resto, done, busy, div_cero
    );
endinterface

// File: rtl/divisor_paso.sv
// One combinational radix-2 restoring division step.
//   rem_in  : current partial remainder (size+1 bits)
//   bit_in  : next dividend bit (MSB first)
//   den     : divisor magnitude
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by this step
module divisor_paso #(
    parameter int size = 8
) (
    input  logic [size:0]   rem_in,
    input  logic            bit_in,
    input  logic [size-1:0] den,
    output logic [size:0]   rem_out,
    output logic            q_bit
);

    logic [size+1:0] shifted_s;
    logic [size+1:0] trial_s;

    // Shift in the dividend bit and trial-subtract; one extra bit keeps the borrow visible.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        trial_s   = shifted_s - {2'b00, den};
        rem_out   = shifted_s[size:0];
        q_bit     = 1'b0;
        if (trial_s[size+1] == 1'b0) begin
            rem_out = trial_s[size:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s[size:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/divisor_param.sv
// Parametrised sequential integer divider (restoring, one quotient bit per clock).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side): start, signo, numerador,
//           denominador in; cociente, resto, done, busy, div_cero out.
// Operates on operand magnitudes for size cycles, then a sign-fix cycle
// writes the results and pulses done. Divide-by-zero skips the iterations.
module divisor_param
    import divisor_pkg::*;
#(
    parameter int size      = DEFAULT_SIZE,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    divisor_param_if.slave bus
);

    localparam int              CW        = cnt_width(size);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST  = CW'(size - 1);
    localparam logic [size-1:0] VAL_ZERO  = {size{1'b0}};
    localparam logic [size-1:0] VAL_ONE   = {{(size-1){1'b0}}, 1'b1};
    localparam logic [size-1:0] VAL_ONES  = {size{1'b1}};
    localparam logic [size:0]   REM_ZERO  = {(size+1){1'b0}};

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [size:0]   rem_r;
    logic [size-1:0] dvd_r;      // dividend magnitude, quotient bits shift in at the LSB
    logic [size-1:0] den_r;      // divisor magnitude
    logic [size-1:0] num_r;      // raw dividend, returned as remainder on divide-by-zero
    logic            q_neg_r;
    logic            r_neg_r;
    logic            zero_r;
    logic [size-1:0] cociente_r;
    logic [size-1:0] resto_r;
    logic            done_r;
    logic            busy_r;
    logic            div_cero_r;

    logic            signed_s;
    logic            num_neg_s;
    logic            den_neg_s;
    logic [size-1:0] num_mag_s;
    logic [size-1:0] den_mag_s;
    logic [size:0]   rem_next_s;
    logic            q_bit_s;

    // Two's-complement negate when n is set; the most negative value maps to 2^(size-1).
    function automatic logic [size-1:0] neg_if(input logic [size-1:0] v, input logic n);
        return n ? (~v + VAL_ONE) : v;
    endfunction

    assign signed_s  = bus.signo & SIGNED_EN;
    assign num_neg_s = signed_s & bus.numerador[size-1];
    assign den_neg_s = signed_s & bus.denominador[size-1];
    assign num_mag_s = neg_if(bus.numerador, num_neg_s);
    assign den_mag_s = neg_if(bus.denominador, den_neg_s);

    divisor_paso #(.size(size)) u_paso (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[size-1]),
        .den     (den_r),
        .rem_out (rem_next_s),
        .q_bit   (q_bit_s)
    );

    // Controller: operand capture, iteration, sign fix and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            rem_r      <= REM_ZERO;
            dvd_r      <= VAL_ZERO;
            den_r      <= VAL_ZERO;
            num_r      <= VAL_ZERO;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            zero_r     <= 1'b0;
            cociente_r <= VAL_ZERO;
            resto_r    <= VAL_ZERO;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            div_cero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        num_r   <= bus.numerador;
                        dvd_r   <= num_mag_s;
                        den_r   <= den_mag_s;
                        rem_r   <= REM_ZERO;
                        q_neg_r <= num_neg_s ^ den_neg_s;
                        r_neg_r <= num_neg_s;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                        if (bus.denominador == VAL_ZERO) begin
                            zero_r  <= 1'b1;
                            state_r <= FIX;
                        end else begin
                            zero_r  <= 1'b0;
                            state_r <= CALC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[size-2:0], q_bit_s};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    if (zero_r) begin
                        cociente_r <= VAL_ONES;
                        resto_r    <= num_r;
                        div_cero_r <= 1'b1;
                    end else begin
                        cociente_r <= neg_if(dvd_r, q_neg_r);
                        resto_r    <= neg_if(rem_r[size-1:0], r_neg_r);
                        div_cero_r <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cociente = cociente_r;
    assign bus.resto    = resto_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.div_cero = div_cero_r;

endmodule

// File: tb/tb_divisor_param.sv
// Directed self-checking bench for divisor_param (size=8, SIGNED_EN=1).
module tb_divisor_param;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   n;
    int   total;
    logic busy_ok;

    divisor_param_if #(.size(8)) bus ();

    divisor_param #(.size(8), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive a request from the current time; returns #1 after the accepting edge.
    task automatic start_op(input logic [7:0] num, input logic [7:0] den, input logic sg);
        bus.start       = 1'b1;
        bus.numerador   = num;
        bus.denominador = den;
        bus.signo       = sg;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done (bounded); tracks busy while waiting.
    task automatic wait_done(output int cnt, output logic bok);
        cnt = 0;
        bok = 1'b1;
        while (cnt < 40) begin
            if (bus.busy !== 1'b1) bok = 1'b0;
            @(posedge clk);
            #1;
            cnt++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic run(input string tag, input logic [7:0] num, input logic [7:0] den,
                       input logic sg, input int lat, input logic [7:0] q,
                       input logic [7:0] r, input logic dz);
        @(negedge clk);
        start_op(num, den, sg);
        wait_done(n, busy_ok);
        check({tag, "_lat"}, n, lat);
        check({tag, "_q"}, bus.cociente, q);
        check({tag, "_r"}, bus.resto, r);
        check({tag, "_dz"}, bus.div_cero, dz);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.signo = 1'b0;
        bus.numerador = 8'd0;
        bus.denominador = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", bus.cociente, 8'd0);
        check("rst_r", bus.resto, 8'd0);
        check("rst_done", bus.done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dz", bus.div_cero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 200/7 with busy tracking and done pulse width.
        run("u200_7", 8'd200, 8'd7, 1'b0, 9, 8'd28, 8'd4, 1'b0);
        check("u200_7_busy", busy_ok, 1'b1);
        check("done_clr_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse", bus.done, 1'b0);
        check("held_q", bus.cociente, 8'd28);

        // Signed cases.
        run("s_m7_2", 8'hF9, 8'h02, 1'b1, 9, 8'hFD, 8'hFF, 1'b0);
        run("s_7_m2", 8'h07, 8'hFE, 1'b1, 9, 8'hFD, 8'h01, 1'b0);

        // Divide by zero, then a normal divide clears the flag.
        run("z45_0", 8'd45, 8'd0, 1'b0, 1, 8'hFF, 8'd45, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("z_held_dz", bus.div_cero, 1'b1);
        run("u10_3", 8'd10, 8'd3, 1'b0, 9, 8'd3, 8'd1, 1'b0);

        // Signed overflow vs. the same bits unsigned.
        run("ovf_s", 8'h80, 8'hFF, 1'b1, 9, 8'h80, 8'h00, 1'b0);
        run("ovf_u", 8'h80, 8'hFF, 1'b0, 9, 8'h00, 8'd128, 1'b0);

        // start while busy is ignored.
        @(negedge clk);
        start_op(8'd50, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.numerador = 8'd9;
        bus.denominador = 8'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        total = n + 4;
        check("ign_lat", total, 9);
        check("ign_q", bus.cociente, 8'd7);
        check("ign_r", bus.resto, 8'd1);

        // start in the done cycle is accepted.
        start_op(8'd9, 8'd4, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        wait_done(n, busy_ok);
        check("b2b_lat", n, 9);
        check("b2b_q", bus.cociente, 8'd2);
        check("b2b_r", bus.resto, 8'd1);

        // Reset mid-CALC.
        @(negedge clk);
        start_op(8'd200, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", bus.cociente, 8'd0);
        check("mid_rst_r", bus.resto, 8'd0);
        check("mid_rst_busy", bus.busy, 1'b0);
        busy_ok = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) busy_ok = 1'b0;
        end
        check("mid_rst_nodone", busy_ok, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run("u100_10", 8'd100, 8'd10, 1'b0, 9, 8'd10, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
